sobel_edge_detect_8bit: RTL and testbench
=========================================

// Module: sobel_edge_detect_8bit
// PURPOSE
//  Consumes the 3x3 window stream from the 3x3 8-bit matrix generator and computes the Sobel
//  gradient magnitude approximation |Gx|+|Gy| for the centre pixel.
//  Outputs either a binary edge map or a saturated 8-bit gradient image.
//  Syncs are delayed to match.
//  Also counts edge pixels per frame and reports the count at each frame boundary.
// PARAMETERS
//  CNT_W       22      width of the per-frame edge-pixel counter (covers 1920x1080)
//  THRESH_DEF  11'd96  value loaded into the frame threshold register at reset
// PORTS
//  clk                 in   1   pixel clock
//  rst_n               in   1   asynchronous, active-low reset
//  matrix_frame_vsync  in   1   frame sync from the matrix generator, active high during a frame
//  matrix_frame_hsync  in   1   line sync, active high during a line
//  matrix_frame_valid  in   1   window valid
//  matrix_pRC          in   8   window pixels, R=row 1..3 (top..bottom), C=col 1..3 (left..right); nine ports
//  threshold           in   11  edge threshold; sampled at frame start only
//  bin_mode            in   1   1: binary edge output; 0: saturated gradient output; sampled at frame start
//  post_frame_vsync    out  1   vsync delayed 3 clk
//  post_frame_hsync    out  1   hsync delayed 3 clk
//  post_frame_valid    out  1   valid delayed 3 clk
//  post_img_y          out  8   result pixel
//  edge_cnt            out  CNT_W  edge-pixel count of the last completed frame
//  frame_done          out  1   1-clk pulse when edge_cnt is updated
// BEHAVIOUR
//  - Reset: all outputs 0; thr_r=THRESH_DEF; mode_r=1; all pipeline registers and the running count are 0.
//  - Pipeline: free-running, no stall, 3 stages. Every register advances on every clk.
//    Invalid cycles flow through with their valid bit.
//  - S1: register the four partial sums, each unsigned 10-bit, max 1020:
//    - gx_p=p13+2*p23+p33
//    - gx_n=p11+2*p21+p31
//    - gy_p=p11+2*p12+p13
//    - gy_n=p31+2*p32+p33
//  - S2: register ax=|gx_p-gx_n| and ay=|gy_p-gy_n|. Use 11-bit signed subtraction, then abs; results are 10-bit.
//  - S3: mag=ax+ay (11-bit, max 2040, no overflow). Output rules:
//    - post_valid=0: post_img_y=8'h00.
//    - post_valid=1, mode_r=1: post_img_y=(mag>=thr_r)?8'hFF:8'h00.
//    - post_valid=1, mode_r=0: post_img_y=(mag>255)?8'hFF:mag[7:0].
//  - Sync delay: vsync/hsync/valid pass through 3-deep shift registers. Output syncs align exactly with post_img_y.
//  - Latency: a window presented at clk edge N appears on the outputs after edge N+3.
//  - Frame start (fs): rising edge of post_frame_vsync, detected with a 1-clk delayed copy. On the fs cycle:
//    - thr_r<=threshold and mode_r<=bin_mode. The new values apply from the next cycle onward.
//    - edge_cnt<=running count, then the running count clears.
//    - frame_done=1 for exactly that cycle.
//  - Edge event: a cycle with post_valid=1 and mag>=thr_r, regardless of mode. The running count increments by 1.
//    It saturates at 2^CNT_W-1 and does not wrap.
//  - Edge event on the fs cycle: the event belongs to the new frame. Running count<=1, and edge_cnt takes the old count.
//  - First fs after reset reports edge_cnt=0 with frame_done=1.
//  - Changes to threshold or bin_mode mid-frame have no effect until the next fs.
//  - Reset asserted mid-frame clears everything immediately (async). No frame_done is generated for the aborted frame.
//    Processing resumes with the first clk after release.
// TESTING
//  - Flat window: all p=100, valid=1 -> mag=0. bin: 00; grey: 00. Counter unchanged.
//  - Vertical edge: col1=0, col3=255, col2=128 -> ax=1020, ay=0, mag=1020.
//    bin: FF; grey: FF (saturated).
//  - Weak edge: p13=p23=p33=10, rest 0 -> mag=40.
//    thr=50,bin -> 00. thr=40,bin -> FF. grey -> 8'd40.
//  - Latency and syncs: single valid pulse at clk 10 with hsync high -> post_valid/hsync high at clk 13 only.
//    Data also valid at clk 13; post_img_y=0 on all other cycles.
//  - Counter: frame with 5 edge pixels (mag>=thr), then vsync low->high -> edge_cnt=5, one frame_done pulse.
//    Next frame with 0 edges -> edge_cnt=0. Edge on the fs cycle -> counted in the next frame.
//  - Reset mid-frame after 3 edges, then a full frame of 2 edges -> outputs 0 during reset.
//    First frame_done after release reports 0; next reports 2.

Source files
------------

// File: rtl/sobel_edge_detect_8bit.sv
// ---------------------------------------------------------------------------
// sobel_edge_detect_8bit
//
// Purpose:
//   Takes the 3x3 window stream from the matrix generator and computes the
//   Sobel gradient magnitude approximation |Gx|+|Gy| for the centre pixel.
//   The result is either a binary edge map (mag >= threshold) or a saturated
//   8-bit gradient image. Frame/line/valid syncs are delayed to stay aligned
//   with the result. Edge pixels are counted per frame and the total is
//   reported at every frame start.
//
// Handshake: there is no back-pressure. matrix_frame_valid qualifies the
//   window in the same cycle; post_frame_valid qualifies post_img_y in the
//   same cycle, exactly 3 clocks later. Every register advances every clock.
//
// Ports:
//   clk, rst_n                 pixel clock, asynchronous active-low reset
//   matrix_frame_vsync/hsync   input frame/line syncs (active high)
//   matrix_frame_valid         input window valid
//   matrix_p11 .. matrix_p33   window pixels, row 1..3 (top..bottom),
//                              column 1..3 (left..right)
//   threshold                  edge threshold, sampled at frame start
//   bin_mode                   1: binary output, 0: grey output; sampled
//                              at frame start
//   post_frame_vsync/hsync     syncs delayed by 3 clocks
//   post_frame_valid           valid delayed by 3 clocks
//   post_img_y                 result pixel (0 when not valid)
//   edge_cnt                   edge-pixel count of the last completed frame
//   frame_done                 1-clock pulse on the cycle edge_cnt is loaded
// ---------------------------------------------------------------------------
module sobel_edge_detect_8bit #(
    parameter int          CNT_W      = 22,
    parameter logic [10:0] THRESH_DEF = 11'd96
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             matrix_frame_vsync,
    input  logic             matrix_frame_hsync,
    input  logic             matrix_frame_valid,
    input  logic [7:0]       matrix_p11,
    input  logic [7:0]       matrix_p12,
    input  logic [7:0]       matrix_p13,
    input  logic [7:0]       matrix_p21,
    input  logic [7:0]       matrix_p22,
    input  logic [7:0]       matrix_p23,
    input  logic [7:0]       matrix_p31,
    input  logic [7:0]       matrix_p32,
    input  logic [7:0]       matrix_p33,
    input  logic [10:0]      threshold,
    input  logic             bin_mode,
    output logic             post_frame_vsync,
    output logic             post_frame_hsync,
    output logic             post_frame_valid,
    output logic [7:0]       post_img_y,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // The centre pixel has zero weight in both Sobel kernels.
    logic unused_p22;
    assign unused_p22 = ^matrix_p22;

    // Sync shift registers; bit 2 is the output stage.
    logic [2:0] vs_sr_q, hs_sr_q, vld_sr_q;

    // Stage 1: partial sums (max 4*255 = 1020).
    logic [9:0] gx_p_d, gx_n_d, gy_p_d, gy_n_d;
    logic [9:0] gx_p_q, gx_n_q, gy_p_q, gy_n_q;

    // Stage 2: absolute differences.
    logic signed [10:0] dx, dy, ndx, ndy;
    logic [9:0]         ax_d, ay_d, ax_q, ay_q;

    // Stage 3: magnitude (max 2040).
    logic [10:0] mag_q;

    // Frame-level state.
    logic             vs_dly_q;
    logic [10:0]      thr_q;
    logic             mode_q;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q;
    logic             fs;
    logic             edge_ev;
    logic [7:0]       img_y;

    always_comb begin
        gx_p_d = {2'b00, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b00, matrix_p33};
        gx_n_d = {2'b00, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b00, matrix_p31};
        gy_p_d = {2'b00, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b00, matrix_p13};
        gy_n_d = {2'b00, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b00, matrix_p33};
    end

    // 11-bit signed difference of two 10-bit values cannot overflow, and its
    // magnitude (<= 1020) always fits back into 10 bits.
    always_comb begin
        dx   = $signed({1'b0, gx_p_q}) - $signed({1'b0, gx_n_q});
        dy   = $signed({1'b0, gy_p_q}) - $signed({1'b0, gy_n_q});
        ndx  = -dx;
        ndy  = -dy;
        ax_d = dx[10] ? ndx[9:0] : dx[9:0];
        ay_d = dy[10] ? ndy[9:0] : dy[9:0];
    end

    // The output stage compares the registered magnitude against the live
    // frame registers, so a threshold/mode loaded at frame start governs
    // every pixel from the following cycle on.
    assign edge_ev = vld_sr_q[2] && (mag_q >= thr_q);
    assign fs      = vs_sr_q[2] && !vs_dly_q;

    always_comb begin
        img_y = 8'h00;
        if (vld_sr_q[2]) begin
            if (mode_q) begin
                img_y = edge_ev ? 8'hFF : 8'h00;
            end else begin
                img_y = (mag_q > 11'd255) ? 8'hFF : mag_q[7:0];
            end
        end
    end

    // An edge on the frame-start cycle belongs to the new frame.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (fs) begin
            run_cnt_d = edge_ev ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        end else if (edge_ev && (run_cnt_q != CNT_MAX)) begin
            run_cnt_d = run_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sr_q    <= '0;
            hs_sr_q    <= '0;
            vld_sr_q   <= '0;
            gx_p_q     <= '0;
            gx_n_q     <= '0;
            gy_p_q     <= '0;
            gy_n_q     <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            mag_q      <= '0;
            vs_dly_q   <= 1'b0;
            thr_q      <= THRESH_DEF;
            mode_q     <= 1'b1;
            run_cnt_q  <= '0;
            edge_cnt_q <= '0;
        end else begin
            vs_sr_q    <= {vs_sr_q[1:0], matrix_frame_vsync};
            hs_sr_q    <= {hs_sr_q[1:0], matrix_frame_hsync};
            vld_sr_q   <= {vld_sr_q[1:0], matrix_frame_valid};
            gx_p_q     <= gx_p_d;
            gx_n_q     <= gx_n_d;
            gy_p_q     <= gy_p_d;
            gy_n_q     <= gy_n_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            mag_q      <= {1'b0, ax_q} + {1'b0, ay_q};
            vs_dly_q   <= vs_sr_q[2];
            run_cnt_q  <= run_cnt_d;
            if (fs) begin
                thr_q      <= threshold;
                mode_q     <= bin_mode;
                edge_cnt_q <= run_cnt_q;
            end
        end
    end

    assign post_frame_vsync = vs_sr_q[2];
    assign post_frame_hsync = hs_sr_q[2];
    assign post_frame_valid = vld_sr_q[2];
    assign post_img_y       = img_y;
    assign edge_cnt         = edge_cnt_q;
    assign frame_done       = fs;

endmodule

// File: tb/tb_sobel_edge_detect_8bit.sv
// Testbench for sobel_edge_detect_8bit: directed windows with hand-computed
// magnitudes; expected pixels and frame counts go into queues that
// independent monitors drain as the DUT presents results.
module tb_sobel_edge_detect_8bit;

  localparam int CNT_W = 22;

  // Window vectors {p11,p12,p13,p21,p22,p23,p31,p32,p33}
  localparam logic [71:0] FLAT = {9{8'd100}};
  localparam logic [71:0] VERT = {8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255};
  localparam logic [71:0] WEAK = {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10};
  localparam logic [71:0] HORZ = {8'd200, 8'd200, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [71:0] G200 = {8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd50};
  localparam logic [71:0] G254 = {8'd0, 8'd0, 8'd63, 8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd63};
  localparam logic [71:0] G256 = {8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd64};
  localparam logic [71:0] NEG  = {8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic             vsync, hsync, valid;
  logic [7:0]       p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [10:0]      threshold;
  logic             bin_mode;
  logic             post_frame_vsync, post_frame_hsync, post_frame_valid;
  logic [7:0]       post_img_y;
  logic [CNT_W-1:0] edge_cnt;
  logic             frame_done;

  sobel_edge_detect_8bit #(.CNT_W(CNT_W), .THRESH_DEF(11'd96)) dut (
    .clk(clk), .rst_n(rst_n),
    .matrix_frame_vsync(vsync), .matrix_frame_hsync(hsync), .matrix_frame_valid(valid),
    .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
    .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
    .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
    .threshold(threshold), .bin_mode(bin_mode),
    .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
    .post_frame_valid(post_frame_valid), .post_img_y(post_img_y),
    .edge_cnt(edge_cnt), .frame_done(frame_done)
  );

  // ---------------- scoreboard ----------------
  logic [9:0]       exp_q[$];      // {vsync, hsync, pixel}
  int unsigned      iss_q[$];      // issue cycle of each window
  logic [CNT_W-1:0] exp_cnt_q[$];  // edge_cnt expected after each frame_done

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  // Model state: thr/mode governing the current frame and its running count.
  logic [10:0]      cur_thr;
  logic             cur_mode;
  logic [CNT_W-1:0] run_cnt;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_frame(input logic [10:0] thr, input logic mode);
    threshold = thr;
    bin_mode  = mode;
    vsync     = 1'b1;
    exp_cnt_q.push_back(run_cnt);
    run_cnt  = '0;
    cur_thr  = thr;
    cur_mode = mode;
  endtask

  task automatic end_frame();
    vsync = 1'b0;
    idle(2);
  endtask

  task automatic send_win(input logic [71:0] pix, input int mag);
    logic [7:0] px;
    {p11, p12, p13, p21, p22, p23, p31, p32, p33} = pix;
    valid = 1'b1;
    hsync = 1'b1;
    if (cur_mode) px = (mag >= int'(cur_thr)) ? 8'hFF : 8'h00;
    else          px = (mag > 255) ? 8'hFF : 8'(mag);
    if (mag >= int'(cur_thr)) run_cnt++;
    exp_q.push_back({vsync, 1'b1, px});
    iss_q.push_back(cyc);
    tick();
    valid = 1'b0;
    hsync = 1'b0;
    {p11, p12, p13, p21, p22, p23, p31, p32, p33} = '0;
  endtask

  // ---------------- monitors ----------------
  logic cnt_pending = 1'b0;

  always @(negedge clk) begin
    logic [9:0] e;
    int unsigned ic;
    if (cnt_pending) begin
      cnt_pending = 1'b0;
      if (exp_cnt_q.size() == 0) begin
        n_checks++;
        $display("FAIL frame_done_unexpected: edge_cnt=%0d with no frame expected, cycle %0d", edge_cnt, cyc);
      end else begin
        check("edge_cnt", 32'(edge_cnt), 32'(exp_cnt_q.pop_front()));
      end
    end
    if (frame_done) cnt_pending = 1'b1;

    if (post_frame_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL valid_unexpected: post_img_y=0x%0h with no window expected, cycle %0d", post_img_y, cyc);
      end else begin
        e  = exp_q.pop_front();
        ic = iss_q.pop_front();
        check("pixel_and_syncs", {22'd0, post_frame_vsync, post_frame_hsync, post_img_y}, {22'd0, e});
        check("latency", cyc - ic, 32'd3);
      end
    end else begin
      check("idle_pixel_zero", {24'd0, post_img_y}, 32'd0);
      check("idle_hsync_low", {31'd0, post_frame_hsync}, 32'd0);
    end
  end

  task automatic check_reset_outputs();
    check("rst_vsync", {31'd0, post_frame_vsync}, 32'd0);
    check("rst_valid", {31'd0, post_frame_valid}, 32'd0);
    check("rst_pixel", {24'd0, post_img_y}, 32'd0);
    check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    vsync = 1'b0; hsync = 1'b0; valid = 1'b0;
    {p11, p12, p13, p21, p22, p23, p31, p32, p33} = '0;
    threshold = 11'd0;
    bin_mode  = 1'b0;
    cur_thr   = 11'd96;
    cur_mode  = 1'b1;
    run_cnt   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // F1: binary, thr=50; first frame_done reports 0.
    start_frame(11'd50, 1'b1); idle(2);
    send_win(FLAT, 0); send_win(VERT, 1020); send_win(WEAK, 40); send_win(HORZ, 800);
    idle(1); end_frame();

    // F2: binary, thr=40; five edges. Inputs change mid-frame with no effect.
    start_frame(11'd40, 1'b1); idle(2);
    send_win(VERT, 1020); send_win(WEAK, 40);
    threshold = 11'd2000; bin_mode = 1'b0;
    send_win(VERT, 1020); idle(1); send_win(FLAT, 0);
    send_win(WEAK, 40); send_win(VERT, 1020);
    idle(1); end_frame();

    // F3: grey, thr=40; saturation boundary 254/256 and negative gradient.
    start_frame(11'd40, 1'b0); idle(2);
    send_win(WEAK, 40); send_win(G200, 200); send_win(G254, 254); send_win(G256, 256);
    send_win(VERT, 1020); send_win(NEG, 200); send_win(FLAT, 0);
    idle(1); end_frame();

    // F4: grey, thr=40, no edges.
    start_frame(11'd40, 1'b0); idle(2);
    send_win(FLAT, 0); send_win(FLAT, 0);
    idle(1); end_frame();

    // F5: edge lands exactly on the frame-start cycle; counted in F5.
    start_frame(11'd40, 1'b0);
    send_win(VERT, 1020); idle(1); send_win(WEAK, 40);
    idle(1); end_frame();

    // F6: aborted by reset after three edges.
    start_frame(11'd40, 1'b1); idle(2);
    send_win(VERT, 1020); send_win(VERT, 1020); send_win(VERT, 1020);
    idle(5);
    rst_n = 1'b0; vsync = 1'b0;
    run_cnt = '0;
    @(negedge clk);
    check_reset_outputs();
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // F7: first frame after reset reports 0; two edges.
    start_frame(11'd40, 1'b1); idle(2);
    send_win(VERT, 1020); send_win(FLAT, 0); send_win(HORZ, 800);
    idle(1); end_frame();

    // F8: reports F7's two edges.
    start_frame(11'd40, 1'b1); idle(6);
    end_frame(); idle(5);

    check("pixel_queue_drained", exp_q.size(), 32'd0);
    check("count_queue_drained", exp_cnt_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
